// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the single-issue core: steps each instruction
// through fetch/decode/execute/memory/writeback and issues exactly one PC update per retired instruction.
module cpu_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                ir_load,
    output logic                alu_go,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_we,
    output logic                pc_inc,
    output logic                pc_branch,
    output logic                halted,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [2:0]          state_out
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(4'h0);
    localparam logic [OPCODE_W-1:0] OP_ALU   = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_HALT  = {OPCODE_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PC_UPD = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timed_out_s;

    // State, wait counter and sticky bus-error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign timed_out_s = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and strobe decode; the counter only survives while a request stays unacked
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        err_d      = err_q;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        alu_go     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (timed_out_s) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP, OP_JMP:                    state_d = S_PC_UPD;
                    OP_ALU, OP_LOAD, OP_STORE, OP_BEQ: state_d = S_EXEC;
                    OP_HALT:                           state_d = S_HALTED;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_PC_UPD;
                    end
                endcase
            end
            S_EXEC: begin
                alu_go = 1'b1;
                case (opcode)
                    OP_ALU:          state_d = S_WB;
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    default:         state_d = S_PC_UPD;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ack) begin
                    if (opcode == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_PC_UPD;
                    end
                end else if (timed_out_s) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                state_d = S_PC_UPD;
            end
            S_PC_UPD: begin
                // alu_zero is valid here because PC_UPD always directly follows EXEC for BEQ
                if ((opcode == OP_JMP) || ((opcode == OP_BEQ) && alu_zero)) begin
                    pc_branch = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                halted  = 1'b1;
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_err   = err_q;
    assign state_out = state_q;

endmodule
